// File: rtl/ifft_butterfly_pipe.sv
// Three-stage radix-2 DIF inverse-FFT butterfly: A' = (A+B)/2, B' = ((A-B)/2) * conj(TW).
// Optional macro IFFT_BFLY_ROUND_EN selects round-half-up; the default build truncates (floor).
module ifft_butterfly_pipe #(
    parameter int BIT_WIDTH = 16
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [BIT_WIDTH-1:0] real_a,
    input  logic signed [BIT_WIDTH-1:0] img_a,
    input  logic signed [BIT_WIDTH-1:0] real_b,
    input  logic signed [BIT_WIDTH-1:0] img_b,
    input  logic signed [BIT_WIDTH-1:0] real_tw,
    input  logic signed [BIT_WIDTH-1:0] img_tw,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [BIT_WIDTH-1:0] real_ap,
    output logic signed [BIT_WIDTH-1:0] img_ap,
    output logic signed [BIT_WIDTH-1:0] real_bp,
    output logic signed [BIT_WIDTH-1:0] img_bp,
    output logic                        ovf
);
    localparam int BW = BIT_WIDTH;
    localparam int PW = 2 * BW;
    localparam int SW = 2 * BW + 2;
    localparam logic signed [BW-1:0] MAX_V = {1'b0, {(BW-1){1'b1}}};
    localparam logic signed [BW-1:0] MIN_V = {1'b1, {(BW-1){1'b0}}};
`ifdef IFFT_BFLY_ROUND_EN
    localparam logic signed [BW+1:0] S1_RND = {{(BW+1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] S3_RND = {{(SW-BW+1){1'b0}}, 1'b1, {(BW-2){1'b0}}};
`endif

    typedef struct packed {
        logic                 v;
        logic signed [BW-1:0] sr, si, dr, di, twr, twi;
    } s1_t;

    typedef struct packed {
        logic                 v;
        logic signed [BW-1:0] sr, si;
        logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    } s2_t;

    typedef struct packed {
        logic                 v;
        logic signed [BW-1:0] rap, iap, rbp, ibp;
        logic                 ovf;
    } s3_t;

    s1_t           s1_q, s1_d;
    s2_t           s2_q, s2_d;
    s3_t           s3_q, s3_d;
    logic          advance_s;
    logic [BW:0]   re_s, im_s;

    // Halving can only leave BW range on the rounded +max - -min difference; clamp that corner.
    function automatic logic signed [BW-1:0] halve(input logic signed [BW+1:0] x);
        logic signed [BW+1:0] t;
`ifdef IFFT_BFLY_ROUND_EN
        t = (x + S1_RND) >>> 1'b1;
`else
        t = x >>> 1'b1;
`endif
        if (t[BW+1:BW-1] == {3{t[BW+1]}}) begin
            halve = t[BW-1:0];
        end else if (t[BW+1]) begin
            halve = MIN_V;
        end else begin
            halve = MAX_V;
        end
    endfunction

    // Returns {saturated, value}: Q-format realignment of a product sum back to BW bits.
    function automatic logic [BW:0] scale_sat(input logic signed [SW-1:0] x);
        logic signed [SW-1:0] t;
`ifdef IFFT_BFLY_ROUND_EN
        t = (x + S3_RND) >>> (BW - 1);
`else
        t = x >>> (BW - 1);
`endif
        if (t[SW-1:BW-1] == {(SW-BW+1){t[SW-1]}}) begin
            scale_sat = {1'b0, t[BW-1:0]};
        end else if (t[SW-1]) begin
            scale_sat = {1'b1, MIN_V};
        end else begin
            scale_sat = {1'b1, MAX_V};
        end
    endfunction

    // All stages move together whenever the output register is empty or being drained.
    always_comb begin
        advance_s = !s3_q.v || out_ready;
        re_s      = scale_sat(SW'(s2_q.p_rr) + SW'(s2_q.p_ii));
        im_s      = scale_sat(SW'(s2_q.p_ir) - SW'(s2_q.p_ri));
        s1_d      = s1_q;
        s2_d      = s2_q;
        s3_d      = s3_q;
        if (advance_s) begin
            s1_d.v    = in_valid;
            s1_d.sr   = halve((BW+2)'(real_a) + (BW+2)'(real_b));
            s1_d.si   = halve((BW+2)'(img_a) + (BW+2)'(img_b));
            s1_d.dr   = halve((BW+2)'(real_a) - (BW+2)'(real_b));
            s1_d.di   = halve((BW+2)'(img_a) - (BW+2)'(img_b));
            s1_d.twr  = real_tw;
            s1_d.twi  = img_tw;
            s2_d.v    = s1_q.v;
            s2_d.sr   = s1_q.sr;
            s2_d.si   = s1_q.si;
            s2_d.p_rr = PW'(s1_q.dr) * PW'(s1_q.twr);
            s2_d.p_ii = PW'(s1_q.di) * PW'(s1_q.twi);
            s2_d.p_ir = PW'(s1_q.di) * PW'(s1_q.twr);
            s2_d.p_ri = PW'(s1_q.dr) * PW'(s1_q.twi);
            s3_d.v    = s2_q.v;
            s3_d.rap  = s2_q.sr;
            s3_d.iap  = s2_q.si;
            s3_d.rbp  = re_s[BW-1:0];
            s3_d.ibp  = im_s[BW-1:0];
            s3_d.ovf  = s3_q.ovf | (s2_q.v & (re_s[BW] | im_s[BW]));
        end else begin
            s1_d = s1_q;
            s2_d = s2_q;
            s3_d = s3_q;
        end
    end

    // Pipeline registers; reset discards every in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign in_ready  = advance_s;
    assign out_valid = s3_q.v;
    assign real_ap   = s3_q.rap;
    assign img_ap    = s3_q.iap;
    assign real_bp   = s3_q.rbp;
    assign img_bp    = s3_q.ibp;
    assign ovf       = s3_q.ovf;

endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Self-checking bench for ifft_butterfly_pipe: directed spec vectors plus randomized traffic
// scored against a complex-arithmetic reference model.
module tb_ifft_butterfly_pipe;
    localparam int BW = 16;
`ifdef IFFT_BFLY_ROUND_EN
    localparam longint RND1 = 64'sd1;
    localparam longint RND3 = 64'sd16384;
    localparam logic [15:0] V1_BR = 16'h1000;
    localparam logic [15:0] V3_AR = 16'h0000;
`else
    localparam longint RND1 = 64'sd0;
    localparam longint RND3 = 64'sd0;
    localparam logic [15:0] V1_BR = 16'h0FFF;
    localparam logic [15:0] V3_AR = 16'hFFFF;
`endif

    logic clk = 1'b0;
    logic reset, in_valid, out_ready, in_ready, out_valid, ovf;
    logic signed [BW-1:0] real_a, img_a, real_b, img_b, real_tw, img_tw;
    logic [BW-1:0] real_ap, img_ap, real_bp, img_bp;

    typedef struct {
        logic [15:0] ar, ai, br, bi;
        bit          sat;
        int          t;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   n_out = 0;
    bit   chk_lat = 1'b0;
    bit   exp_ovf = 1'b0;

    always #5 clk = ~clk;

    ifft_butterfly_pipe #(.BIT_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .real_a(real_a), .img_a(img_a), .real_b(real_b), .img_b(img_b),
        .real_tw(real_tw), .img_tw(img_tw), .out_valid(out_valid), .out_ready(out_ready),
        .real_ap(real_ap), .img_ap(img_ap), .real_bp(real_bp), .img_bp(img_bp), .ovf(ovf)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [15:0] clamp16(input longint x, output bit s);
        s = 1'b0;
        if (x > 64'sd32767) begin
            s = 1'b1;
            return 16'h7FFF;
        end
        if (x < -64'sd32768) begin
            s = 1'b1;
            return 16'h8000;
        end
        return 16'(x);
    endfunction

    // Reference: halve sum/diff, then B' = d * conj(tw) in Q1.15 with floor (or half-up) scaling.
    function automatic exp_t model(input longint a_re, input longint a_im, input longint b_re,
                                   input longint b_im, input longint w_re, input longint w_im);
        exp_t   m;
        bit     s0, s1, s2;
        longint dr, di, re, im;
        m.ar = clamp16((a_re + b_re + RND1) >>> 1, s0);
        m.ai = clamp16((a_im + b_im + RND1) >>> 1, s0);
        dr   = longint'($signed(clamp16((a_re - b_re + RND1) >>> 1, s0)));
        di   = longint'($signed(clamp16((a_im - b_im + RND1) >>> 1, s0)));
        re   = dr * w_re + di * w_im;
        im   = di * w_re - dr * w_im;
        m.br = clamp16((re + RND3) >>> 15, s1);
        m.bi = clamp16((im + RND3) >>> 15, s2);
        m.sat = s1 | s2;
        m.t   = 0;
        return m;
    endfunction

    function automatic exp_t mk(input logic [15:0] ar, input logic [15:0] ai,
                                input logic [15:0] br, input logic [15:0] bi, input bit sat);
        exp_t m;
        m.ar = ar; m.ai = ai; m.br = br; m.bi = bi; m.sat = sat; m.t = 0;
        return m;
    endfunction

    function automatic logic [15:0] rnd16();
        case ($urandom_range(0, 7))
            0:       return 16'h7FFF;
            1:       return 16'h8000;
            default: return 16'($urandom);
        endcase
    endfunction

    task automatic set_in(input logic [15:0] ar, input logic [15:0] ai, input logic [15:0] br,
                          input logic [15:0] bi, input logic [15:0] wr, input logic [15:0] wi);
        real_a = ar; img_a = ai; real_b = br; img_b = bi; real_tw = wr; img_tw = wi;
    endtask

    task automatic set_rand();
        set_in(rnd16(), rnd16(), rnd16(), rnd16(), rnd16(), rnd16());
        pend = model(real_a, img_a, real_b, img_b, real_tw, img_tw);
    endtask

    // One clock: score visible output against queue head, record an accepted input.
    task automatic tick(output bit acc, output bit ov);
        exp_t e;
        bit   cur;
        #1;
        ov  = out_valid;
        acc = in_valid && in_ready;
        if (out_valid) begin
            check("out_valid_has_pending", q.size() > 0, 32'd1);
            if (q.size() > 0) begin
                e   = q[0];
                cur = exp_ovf | e.sat;
                check("real_ap", real_ap, e.ar);
                check("img_ap", img_ap, e.ai);
                check("real_bp", real_bp, e.br);
                check("img_bp", img_bp, e.bi);
                check("ovf_busy", ovf, cur);
                if (out_ready) begin
                    if (chk_lat) check("latency", cyc - e.t, 32'd3);
                    exp_ovf = cur;
                    void'(q.pop_front());
                    n_out++;
                end
            end
        end else begin
            check("ovf_idle", ovf, exp_ovf);
        end
        if (acc) begin
            pend.t = cyc;
            q.push_back(pend);
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic send_exp(input exp_t e);
        bit a, o;
        a = 1'b0;
        pend = e;
        in_valid = 1'b1;
        for (int i = 0; i < 20 && !a; i++) tick(a, o);
        check("send_accepted", a, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic flush();
        bit a, o;
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30 && q.size() > 0; i++) tick(a, o);
        check("drained", q.size(), 32'd0);
    endtask

    task automatic check_reset_state();
        check("rst_out_valid", out_valid, 32'd0);
        check("rst_in_ready", in_ready, 32'd1);
        check("rst_ovf", ovf, 32'd0);
        check("rst_real_ap", real_ap, 32'd0);
        check("rst_img_ap", img_ap, 32'd0);
        check("rst_real_bp", real_bp, 32'd0);
        check("rst_img_bp", img_bp, 32'd0);
    endtask

    initial begin
        bit a, o;
        int n0;
        reset = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        set_in(16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        #1;
        check_reset_state();
        @(negedge clk);
        reset = 1'b0;

        // Directed spec vectors with free-flowing output.
        out_ready = 1'b1;
        chk_lat = 1'b1;
        set_in(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
        send_exp(mk(16'h3000, 16'h0000, V1_BR, 16'h0000, 1'b0));
        flush();
        set_in(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h7FFF);
        send_exp(mk(16'h3000, 16'h0000, 16'h0000, 16'hF000, 1'b0));
        flush();
        check("ovf_before_sat", ovf, 32'd0);
        set_in(16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h7FFF, 16'h7FFF);
        send_exp(mk(V3_AR, V3_AR, 16'h7FFF, 16'h0000, 1'b1));
        flush();
        check("ovf_after_sat", ovf, 32'd1);
        set_in(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h7FFF, 16'h0000);
        send_exp(mk(16'h3000, 16'h0000, V1_BR, 16'h0000, 1'b0));
        flush();
        check("ovf_sticky", ovf, 32'd1);

        // Backpressure: three fill the pipe, the fourth waits until out_ready rises.
        chk_lat = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            set_rand();
            in_valid = 1'b1;
            tick(a, o);
            check("stall_fill_accept", a, 32'd1);
        end
        set_rand();
        in_valid = 1'b1;
        #1;
        check("in_ready_fell", in_ready, 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick(a, o);
            check("stall_in_blocked", a, 32'd0);
            check("stall_out_valid", o, 32'd1);
        end
        out_ready = 1'b1;
        tick(a, o);
        check("stall_release_accept", a, 32'd1);
        check("stall_release_out", o, 32'd1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(a, o);
            check("drain_back_to_back", o, 32'd1);
        end
        check("stall_all_out", q.size(), 32'd0);

        // Continuous stream of 8 at full throughput, latency 3.
        chk_lat = 1'b1;
        n0 = n_out;
        for (int k = 0; k < 8; k++) begin
            set_rand();
            in_valid = 1'b1;
            tick(a, o);
            check("stream_accept", a, 32'd1);
        end
        flush();
        check("stream_count", n_out - n0, 32'd8);

        // Randomized valid/ready traffic.
        chk_lat = 1'b0;
        for (int k = 0; k < 400; k++) begin
            set_rand();
            in_valid = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            tick(a, o);
        end
        flush();

        // Reset with two operations in flight.
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            set_rand();
            in_valid = 1'b1;
            tick(a, o);
        end
        in_valid = 1'b0;
        check("inflight_before_reset", q.size(), 32'd2);
        reset = 1'b1;
        #1;
        check_reset_state();
        q.delete();
        exp_ovf = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 4; k++) tick(a, o);
        chk_lat = 1'b1;
        set_in(16'h4000, 16'h0000, 16'h2000, 16'h0000, 16'h0000, 16'h7FFF);
        send_exp(mk(16'h3000, 16'h0000, 16'h0000, 16'hF000, 1'b0));
        flush();
        check("ovf_after_reset", ovf, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
